unidade_controle_jogo: RTL and testbench

//   Moore FSM that sequences the experiment-4 datapath: clears counter and register,

---
 rtl/unidade_controle_jogo.sv | 156 +++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore control unit for the experiment-4 game datapath.
// It clears the counter and move register, waits for each played move, latches it,
// checks it against the ROM and steps the address until a mistake or the last address.
// Optional macro TIMEOUT_EN adds an idle timer in ESPERA that ends the round in
// FIM_TIMEOUT after TIMEOUT_CYCLES cycles without a move.
module unidade_controle_jogo #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // The enum values double as the debug display codes.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARACAO  = 4'h4,
        PROXIMO     = 4'h5,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    estado_t state_q, state_d;

    // A timer window shorter than two cycles cannot be represented sensibly.
    if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
        $error("unidade_controle_jogo: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeoutHit;

    assign timeoutHit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Timer only runs while the FSM keeps waiting in ESPERA, so every fresh entry
    // into ESPERA (and every other state) sees it at zero.
    always_comb begin
        timer_d = '0;
        if (state_q == ESPERA && state_d == ESPERA) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Timer register, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`endif

    // State register; reset drops straight back to INICIAL without waiting for a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; inputs are only looked at in the states that use them.
    always_comb begin
        state_d = INICIAL;
        case (state_q)
            INICIAL:    state_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: state_d = ESPERA;
            ESPERA: begin
                if (jogada_feita) begin
                    state_d = REGISTRA;
`ifdef TIMEOUT_EN
                end else if (timeoutHit) begin
                    state_d = FIM_TIMEOUT;
`endif
                end else begin
                    state_d = ESPERA;
                end
            end
            REGISTRA:   state_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    state_d = FIM_ERRO;
                end else if (fimC) begin
                    state_d = FIM_ACERTO;
                end else begin
                    state_d = PROXIMO;
                end
            end
            PROXIMO:    state_d = ESPERA;
            FIM_ACERTO: state_d = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:   state_d = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: state_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:    state_d = INICIAL;
        endcase
    end

    // Moore output decode from the state register alone.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:   registraR = 1'b1;
            PROXIMO:    contaC    = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
`ifdef TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado = state_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: vector table, hand sequences and randomized run against
// a round-level model of the game controller.
module tb_unidade_controle_jogo;

   localparam int TO = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       jogada_feita = 1'b0;
   logic       igual = 1'b0;
   logic       fimC = 1'b0;
   logic       zeraC, contaC, zeraR, registraR;
   logic       pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         ini;
      bit         jog;
      bit         igu;
      bit         fim;
      logic [3:0] expState;
   } vec_t;

   vec_t vecs[$];

   unidade_controle_jogo #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada_feita(jogada_feita),
      .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR),
      .registraR(registraR), .pronto(pronto), .acertou(acertou), .errou(errou),
      .timeout(timeout), .db_estado(db_estado)
   );

   // 10 ns clock period
   always #5 clock = ~clock;

   // Expected output bundle {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}
   function automatic logic [7:0] expOut(input logic [3:0] code);
      case (code)
         4'h1: return 8'b1010_0000;
         4'h3: return 8'b0001_0000;
         4'h5: return 8'b0100_0000;
         4'hA: return 8'b0000_1100;
         4'hE: return 8'b0000_1010;
`ifdef TIMEOUT_EN
         4'hD: return 8'b0000_1001;
`endif
         default: return 8'b0000_0000;
      endcase
   endfunction

   task automatic applyStimulus(input bit ini, input bit jog, input bit igu, input bit fim);
      iniciar      = ini;
      jogada_feita = jog;
      igual        = igu;
      fimC         = fim;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expState);
      logic [7:0] act;
      act = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
      checks++;
      if (db_estado !== expState) begin
         errors++;
         $display("[TB] FAIL %s state: got %h expected %h", name, db_estado, expState);
      end
      checks++;
      if (act !== expOut(expState)) begin
         errors++;
         $display("[TB] FAIL %s outputs: got %b expected %b", name, act, expOut(expState));
      end
   endtask

   // One rising edge, then settle before sampling
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic countCheck(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Round-level reference: where the game goes next, given the rules of play
   int modelWait = 0;
   function automatic logic [3:0] modelNext(input logic [3:0] code, input bit ini,
                                            input bit jog, input bit igu, input bit fim);
      logic [3:0] nxt;
      nxt = 4'h0;
      if (code == 4'h0 || code == 4'hA || code == 4'hE || code == 4'hD)
         nxt = ini ? 4'h1 : ((code == 4'h0) ? 4'h0 : code);
      else if (code == 4'h1 || code == 4'h5)
         nxt = 4'h2;
      else if (code == 4'h3)
         nxt = 4'h4;
      else if (code == 4'h4)
         nxt = !igu ? 4'hE : (fim ? 4'hA : 4'h5);
      else if (code == 4'h2) begin
         modelWait++;
         nxt = 4'h2;
         if (jog) nxt = 4'h3;
`ifdef TIMEOUT_EN
         else if (modelWait == TO) nxt = 4'hD;
`endif
      end
      if (nxt != 4'h2) modelWait = 0;
      return nxt;
   endfunction

   initial begin
      int regCount, contaCount;
      logic [3:0] mcode;
      bit ri, rj, rg, rf;

      // Reset held for two cycles, then released
      applyStimulus(0, 0, 0, 0);
      reset = 1'b0;
      step();
      checkOutput("reset_c1", 4'h0);
      step();
      checkOutput("reset_c2", 4'h0);
      @(negedge clock);
      reset = 1'b1;
      step();
      checkOutput("idle_after_reset", 4'h0);

      // Vector table: inputs sampled at the edge, state expected after it
      vecs.push_back('{0,0,0,0,4'h0});
      vecs.push_back('{1,0,0,0,4'h1});
      vecs.push_back('{0,0,0,0,4'h2});
      vecs.push_back('{0,0,0,0,4'h2});
      vecs.push_back('{0,1,0,0,4'h3});
      vecs.push_back('{0,0,1,0,4'h4});
      vecs.push_back('{0,0,1,0,4'h5});
      vecs.push_back('{0,1,1,0,4'h2});
      vecs.push_back('{0,0,1,0,4'h2});
      vecs.push_back('{0,1,1,0,4'h3});
      vecs.push_back('{0,1,1,0,4'h4});
      vecs.push_back('{0,0,0,0,4'hE});
      vecs.push_back('{0,1,0,0,4'hE});
      vecs.push_back('{1,0,0,0,4'h1});
      vecs.push_back('{0,0,0,0,4'h2});
      vecs.push_back('{0,1,0,0,4'h3});
      vecs.push_back('{0,0,0,0,4'h4});
      vecs.push_back('{0,0,1,1,4'hA});
      vecs.push_back('{0,1,0,0,4'hA});
      vecs.push_back('{1,0,0,0,4'h1});
      vecs.push_back('{0,0,0,0,4'h2});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].ini, vecs[i].jog, vecs[i].igu, vecs[i].fim);
         step();
         checkOutput($sformatf("vec%0d", i), vecs[i].expState);
      end

      // Full 16-move winning round from ESPERA
      regCount = 0;
      contaCount = 0;
      for (int m = 1; m <= 16; m++) begin
         applyStimulus(0, 1, 0, 0);
         step();
         regCount += registraR;
         checkOutput("win_reg", 4'h3);
         applyStimulus(0, 0, 0, 0);
         step();
         checkOutput("win_cmp", 4'h4);
         applyStimulus(0, 0, 1, m == 16);
         step();
         contaCount += contaC;
         if (m < 16) begin
            checkOutput("win_next", 4'h5);
            applyStimulus(0, 0, 0, 0);
            step();
         end
      end
      checkOutput("win_end", 4'hA);
      countCheck("win_registraR_count", regCount, 16);
      countCheck("win_contaC_count", contaCount, 15);

      // Wrong third move
      applyStimulus(1, 0, 0, 0);
      step();
      checkOutput("err_prep", 4'h1);
      applyStimulus(0, 0, 0, 0);
      step();
      for (int m = 1; m <= 3; m++) begin
         applyStimulus(0, 1, 0, 0);
         step();
         applyStimulus(0, 0, 0, 0);
         step();
         applyStimulus(0, 0, m != 3, 0);
         step();
         if (m < 3) begin
            applyStimulus(0, 0, 0, 0);
            step();
         end
      end
      checkOutput("err_end", 4'hE);
      applyStimulus(1, 0, 0, 0);
      step();
      checkOutput("err_restart", 4'h1);
      applyStimulus(0, 0, 0, 0);
      step();
      checkOutput("err_wait", 4'h2);

`ifdef TIMEOUT_EN
      // Idle window expires after TO cycles in ESPERA
      for (int k = 1; k < TO; k++) step();
      checkOutput("to_still_waiting", 4'h2);
      step();
      checkOutput("to_fired", 4'hD);
      applyStimulus(1, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0);
      step();
      checkOutput("to_rearm", 4'h2);
      for (int k = 1; k < TO; k++) step();
      applyStimulus(0, 1, 0, 0);
      step();
      checkOutput("to_move_wins", 4'h3);
      applyStimulus(0, 0, 1, 0);
      step();
      step();
      applyStimulus(0, 0, 0, 0);
      step();
      checkOutput("to_back_wait", 4'h2);
`else
      // Without the timer the FSM just keeps waiting
      for (int k = 0; k < 3 * TO; k++) step();
      checkOutput("no_timeout", 4'h2);
`endif

      // Asynchronous reset while in COMPARACAO
      applyStimulus(0, 1, 0, 0);
      step();
      applyStimulus(0, 0, 1, 0);
      step();
      checkOutput("pre_async", 4'h4);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async_reset", 4'h0);
      @(negedge clock);
      reset = 1'b1;
      step();
      checkOutput("after_async", 4'h0);

      // Randomized play against the round-level model
      mcode = 4'h0;
      modelWait = 0;
      for (int n = 0; n < 600; n++) begin
         ri = ($urandom_range(0, 9) == 0);
         rj = ($urandom_range(0, 5) == 0);
         rg = ($urandom_range(0, 7) != 0);
         rf = ($urandom_range(0, 5) == 0);
         applyStimulus(ri, rj, rg, rf);
         mcode = modelNext(mcode, ri, rj, rg, rf);
         step();
         checkOutput("random", mcode);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
